seq_generator: RTL

Serial pattern transmitter that produces the single-bit stream `w` consumed by `seq_detector`. A host loads a pattern word, a bit length and a repeat count. The block shifts the pattern out MSB-first at a programmable bit rate, with optional idle gaps between repetitions. It sits on the transmit side of the serial-sequence link, typically driving `seq_detector` directly in loopback tests.

---
 rtl/seq_gen_pkg.sv | 22 ++
 rtl/seq_tick_gen.sv | 38 +++
 rtl/seq_generator.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
package seq_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int unsigned REP_W = 4;

   // Lengths beyond the pattern register are sent as a full-width pattern.
   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
      if (len > width) begin
         return width;
      end else begin
         return len;
      end
   endfunction

endpackage

// File: rtl/seq_tick_gen.sv
// Bit-period prescaler: strobes bit_end_o on the last cycle of every bit period.
module seq_tick_gen #(
   parameter int unsigned BIT_DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart_i,
   output logic bit_end_o
);

   localparam int unsigned     CNT_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // With BIT_DIV=1 the counter never leaves zero, so bit_end_o stays high.
   always_comb begin
      cnt_d = cnt_q;
      if (restart_i || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Cycle counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_end_o = (cnt_q == LAST);

endmodule

// File: rtl/seq_generator.sv
// Serial pattern transmitter: shifts a loaded pattern out MSB-first on w,
// repeating it with optional idle gaps between repetitions.
module seq_generator
   import seq_gen_pkg::*;
#(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned LEN_W   = 5,
   parameter int unsigned BIT_DIV = 1,
   parameter int unsigned GAP     = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] pattern,
   input  logic [LEN_W-1:0] length,
   input  logic [REP_W-1:0] repeat_cnt,
   input  logic             abort,
   output logic             w,
   output logic             busy,
   output logic             done
);

   localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             w_q, w_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             accept_s;
   logic             bit_end_s;
   logic             restart_s;
   logic [LEN_W-1:0] len_clamp_s;
   logic [IDX_W-1:0] reload_idx_s;

   assign load_ready   = (state_q == ST_IDLE) && !abort && rst_n;
   assign accept_s     = load_valid && load_ready;
   assign len_clamp_s  = LEN_W'(clamp_len(32'(length), WIDTH));
   assign reload_idx_s = IDX_W'(len_q - LEN_W'(1));

   // Every state change (accept, wrap into GAP, return to SHIFT) starts a fresh bit period.
   assign restart_s = (state_d != state_q);

   seq_tick_gen #(
      .BIT_DIV (BIT_DIV)
   ) u_tick (
      .clk       (clk),
      .rst_n     (rst_n),
      .restart_i (restart_s),
      .bit_end_o (bit_end_s)
   );

   // Next-state logic for the FSM, bit index, repetition and gap counters.
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      idx_d   = idx_q;
      rep_d   = rep_q;
      gap_d   = gap_q;

      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               pat_d = pattern;
               len_d = len_clamp_s;
               rep_d = repeat_cnt;
               idx_d = IDX_W'(len_clamp_s - LEN_W'(1));
               if (len_clamp_s != '0) begin
                  state_d = ST_SHIFT;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (bit_end_s) begin
               if (idx_q != '0) begin
                  idx_d = idx_q - IDX_W'(1);
               end else if (rep_q != '0) begin
                  rep_d = rep_q - REP_W'(1);
                  if (GAP > 0) begin
                     state_d = ST_GAP;
                     gap_d   = GAP_W'(GAP - 1);
                  end else begin
                     idx_d = reload_idx_s;
                  end
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_GAP: begin
            if (bit_end_s) begin
               if (gap_q == '0) begin
                  state_d = ST_SHIFT;
                  idx_d   = reload_idx_s;
               end else begin
                  gap_d = gap_q - GAP_W'(1);
               end
            end else begin
               state_d = ST_GAP;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
      end else begin
         state_d = state_d;
      end
   end

   // Outputs are derived from the next state so they are registered yet aligned with it.
   always_comb begin
      w_d    = 1'b0;
      busy_d = (state_d == ST_SHIFT) || (state_d == ST_GAP);
      done_d = (state_d == ST_DONE);
      if (state_d == ST_SHIFT) begin
         w_d = pat_d[idx_d];
      end else begin
         w_d = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pat_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         rep_q   <= '0;
         gap_q   <= '0;
         w_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         rep_q   <= rep_d;
         gap_q   <= gap_d;
         w_q     <= w_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign w    = w_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
